// File: rtl/gate_response_checker_if.sv
// Stimulus/response and result bundle between a NAND-tree bench driver and gate_response_checker.
// Every signal is a per-cycle level; there is no backpressure: a pair is taken whenever in_valid is high in CHECK.
interface gate_response_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             in_valid;
    logic [3:0]       stim;
    logic [2:0]       resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [15:0]      cov_mask;
    logic [3:0]       first_fail_stim;
    logic [2:0]       first_fail_resp;

    modport master (
        output start, in_valid, stim, resp,
        input  busy, done, pass, err_count, cov_mask, first_fail_stim, first_fail_resp
    );

    modport slave (
        input  start, in_valid, stim, resp,
        output busy, done, pass, err_count, cov_mask, first_fail_stim, first_fail_resp
    );
endinterface

// File: rtl/gate_response_checker.sv
// Checks a four-input NAND-tree response stream against its golden function, tracking coverage and errors.
// Optional first-fail capture registers are built when CHECKER_FIRST_FAIL_EN is defined.
module gate_response_checker #(
    parameter int MAX_SAMPLES = 64,
    parameter int ERR_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    gate_response_checker_if.slave  bus,
    output logic [1:0]              o_state
);
    localparam int CNT_W = $clog2(MAX_SAMPLES + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [15:0]      r_cov;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic [2:0]       w_golden;
    logic             w_mismatch;
    logic [15:0]      w_cov_next;
    logic [ERR_W-1:0] w_err_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_finish;

    assign w_accept   = (r_state == CHECK) && bus.in_valid && !bus.start;
    assign w_golden   = {~(bus.stim[3] & bus.stim[2]),
                         ~(bus.stim[1] & bus.stim[0]),
                         ~(&bus.stim)};
    assign w_mismatch = (bus.resp != w_golden);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // Next-cycle datapath values; they equal the current values whenever nothing is accepted.
    assign w_cov_next = w_accept ? (r_cov | (16'h0001 << bus.stim)) : r_cov;
    assign w_err_next = (w_accept && w_mismatch && (r_err != {ERR_W{1'b1}}))
                        ? r_err + ERR_W'(1) : r_err;
    assign w_finish   = (w_cov_next == 16'hFFFF) || (w_cnt_inc == MAX_CNT);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = CHECK;
            CHECK: begin
                if (bus.start)                  w_next_state = CHECK;
                else if (w_accept && w_finish)  w_next_state = DONE;
            end
            DONE:    if (bus.start) w_next_state = CHECK;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_cov   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == CHECK);
            r_done  <= (w_next_state == DONE);
            r_pass  <= (w_next_state == DONE) && (w_err_next == '0) && (w_cov_next == 16'hFFFF);
            if (bus.start) begin
                r_err <= '0;
                r_cov <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_err <= w_err_next;
                r_cov <= w_cov_next;
                r_cnt <= w_cnt_inc;
            end
        end
    end

`ifdef CHECKER_FIRST_FAIL_EN
    logic [3:0] r_ff_stim;
    logic [2:0] r_ff_resp;
    logic       r_ff_seen;

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            r_ff_stim <= '0;
            r_ff_resp <= '0;
            r_ff_seen <= 1'b0;
        end else if (w_accept && w_mismatch && !r_ff_seen) begin
            r_ff_stim <= bus.stim;
            r_ff_resp <= bus.resp;
            r_ff_seen <= 1'b1;
        end
    end

    assign bus.first_fail_stim = r_ff_stim;
    assign bus.first_fail_resp = r_ff_resp;
`else
    assign bus.first_fail_stim = '0;
    assign bus.first_fail_resp = '0;
`endif

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.cov_mask  = r_cov;
    assign o_state       = r_state;
endmodule

// File: tb/tb_gate_response_checker.sv
// Directed and randomized checks of gate_response_checker against a set-based behavioural model.
module tb_gate_response_checker;
  localparam int MAX_SAMPLES = 32;
  localparam int ERR_W       = 2;
  localparam int ERR_MAX     = (1 << ERR_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_tests = 0;
  int         n_fail  = 0;

  gate_response_checker_if #(.ERR_W(ERR_W)) bus ();

  gate_response_checker #(.MAX_SAMPLES(MAX_SAMPLES), .ERR_W(ERR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;

  // model: mode 0 idle, 1 checking, 2 finished
  int         m_mode;
  bit         m_seen[16];
  int         m_samples;
  int         m_err;
  logic [3:0] m_ff_stim;
  logic [2:0] m_ff_resp;
  bit         m_ff_valid;

  function automatic logic [2:0] golden(input logic [3:0] s);
    bit a, b, c, d;
    a = s[3]; b = s[2]; c = s[1]; d = s[0];
    return {!(a && b), !(c && d), !(a && b && c && d)};
  endfunction

  function automatic int seen_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += m_seen[i];
    return n;
  endfunction

  function automatic logic [15:0] seen_mask();
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) if (m_seen[i]) m = m | (16'h0001 << i);
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_seen[i] = 1'b0;
    m_samples  = 0;
    m_err      = 0;
    m_ff_stim  = '0;
    m_ff_resp  = '0;
    m_ff_valid = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit v, input logic [3:0] s, input logic [2:0] r);
    if (st) begin
      model_clear();
      m_mode = 1;
    end else if (m_mode == 1 && v) begin
      m_seen[s] = 1'b1;
      m_samples++;
      if (r != golden(s)) begin
        if (m_err < ERR_MAX) m_err++;
        if (!m_ff_valid) begin
          m_ff_stim  = s;
          m_ff_resp  = r;
          m_ff_valid = 1'b1;
        end
      end
      if (seen_count() == 16 || m_samples == MAX_SAMPLES) m_mode = 2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_mode == 1));
    chk({tag, ".done"}, 32'(bus.done), 32'(m_mode == 2));
    chk({tag, ".pass"}, 32'(bus.pass), 32'(m_mode == 2 && m_err == 0 && seen_count() == 16));
    chk({tag, ".err"},  32'(bus.err_count), 32'(m_err));
    chk({tag, ".cov"},  32'(bus.cov_mask), 32'(seen_mask()));
    chk({tag, ".state"}, 32'(dbg_state), 32'(m_mode));
`ifdef CHECKER_FIRST_FAIL_EN
    chk({tag, ".ffs"}, 32'(bus.first_fail_stim), 32'(m_ff_stim));
    chk({tag, ".ffr"}, 32'(bus.first_fail_resp), 32'(m_ff_resp));
`else
    chk({tag, ".ffs"}, 32'(bus.first_fail_stim), 32'd0);
    chk({tag, ".ffr"}, 32'(bus.first_fail_resp), 32'd0);
`endif
  endtask

  task automatic step(input string tag, input bit st, input bit v,
                      input logic [3:0] s, input logic [2:0] r);
    bus.start    = st;
    bus.in_valid = v;
    bus.stim     = s;
    bus.resp     = r;
    @(posedge clk);
    model_edge(st, v, s, r);
    #1;
    check_all(tag);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    model_clear();
    m_mode = 0;
    #1;
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.stim = '0; bus.resp = '0;
    model_clear();
    m_mode = 0;

    // reset values and samples ignored in IDLE
    do_reset("reset");
    step("idle_ignore", 1'b0, 1'b1, 4'h3, 3'b000);

    // full sweep with correct responses
    step("sweep_start", 1'b1, 1'b0, 4'h0, 3'b000);
    for (int i = 0; i < 16; i++) step("sweep", 1'b0, 1'b1, 4'(i), golden(4'(i)));
    chk("sweep_done", 32'(bus.done), 32'd1);
    chk("sweep_pass", 32'(bus.pass), 32'd1);
    chk("sweep_cov", 32'(bus.cov_mask), 32'hFFFF);
    chk("golden_0", 32'(golden(4'h0)), 32'b111);
    chk("golden_C", 32'(golden(4'hC)), 32'b011);
    step("done_ignore", 1'b0, 1'b1, 4'hF, 3'b101);

    // single fault at stim F
    step("fault_start", 1'b1, 1'b0, 4'h0, 3'b000);
    for (int i = 0; i < 16; i++)
      step("fault", 1'b0, 1'b1, 4'(i), (i == 15) ? 3'b111 : golden(4'(i)));
    chk("fault_err", 32'(bus.err_count), 32'd1);
    chk("fault_pass", 32'(bus.pass), 32'd0);
    chk("fault_done", 32'(bus.done), 32'd1);

    // budget exhaustion with a single repeated stimulus
    step("budget_start", 1'b1, 1'b0, 4'h0, 3'b000);
    for (int i = 0; i < MAX_SAMPLES; i++) begin
      chk("budget_not_done", 32'(bus.done), 32'd0);
      step("budget", 1'b0, 1'b1, 4'h0, 3'b111);
    end
    chk("budget_done", 32'(bus.done), 32'd1);
    chk("budget_cov", 32'(bus.cov_mask), 32'h0001);
    chk("budget_pass", 32'(bus.pass), 32'd0);

    // saturation: 1,2,3,3,3
    step("sat_start", 1'b1, 1'b0, 4'h0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      step("sat", 1'b0, 1'b1, 4'h0, 3'b000);
      chk("sat_val", 32'(bus.err_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // reset mid-run, then samples ignored until start
    step("mid_start", 1'b1, 1'b0, 4'h0, 3'b000);
    for (int i = 0; i < 5; i++) step("mid", 1'b0, 1'b1, 4'(i + 4), 3'b000);
    do_reset("mid_reset");
    chk("mid_state", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 3; i++) step("post_reset_ignore", 1'b0, 1'b1, 4'(i), 3'b000);

    // restart while busy with a simultaneous sample
    step("rs_start", 1'b1, 1'b0, 4'h0, 3'b000);
    for (int i = 0; i < 3; i++) step("rs_err", 1'b0, 1'b1, 4'(i), 3'b010);
    step("rs_restart", 1'b1, 1'b1, 4'h9, 3'b000);
    chk("rs_err0", 32'(bus.err_count), 32'd0);
    chk("rs_cov0", 32'(bus.cov_mask), 32'd0);
    chk("rs_busy", 32'(bus.busy), 32'd1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int roll;
      logic [3:0] s;
      logic [2:0] r;
      roll = $urandom_range(0, 99);
      s    = 4'($urandom_range(0, 15));
      r    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : golden(s);
      if (roll < 2) do_reset("rnd_reset");
      else step("rnd", roll < 7, $urandom_range(0, 3) != 0, s, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Response-side companion to the gate-level stimulus counters used across the week-4 NAND labs. It accepts one (stimulus, response) pair per valid cycle from a four-input NAND-tree DUT and compares the response against the golden function. It accumulates a saturating mismatch count and a 16-bit input-coverage mask, then reports done/pass once all 16 input combinations are seen or a sample budget runs out. It sits beside the DUT in benches and in board-level self-test wrappers, replacing manual waveform inspection.

## Interface
- MAX_SAMPLES, 64: accepted-sample budget before forced completion (≥16, ≤65535).
- ERR_W, 8: width of the saturating error counter.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears all state and begins a run.
- in_valid  in  1  stim/resp pair valid this cycle.
- stim  in  4  DUT inputs {a,b,c,d}; a = stim[3].
- resp  in  3  DUT outputs {e,f,g}; e = resp[2].
- busy  out  1  high in CHECK.
- done  out  1  high in DONE.
- pass  out  1  high in DONE iff err_count==0 and cov_mask==16'hFFFF.
- err_count  out  ERR_W  mismatch count, saturating.
- cov_mask  out  16  bit n set once stim==n has been accepted.
- first_fail_stim  out  4  stim of the first mismatch.
- first_fail_resp  out  3  resp of the first mismatch.

## Operation
- Golden function: e = ~(a&b), f = ~(c&d), g = ~(a&b&c&d).
- FSM states: IDLE, CHECK, DONE.
  - IDLE → CHECK on start.
  - CHECK → DONE when the accepted sample completes coverage or reaches MAX_SAMPLES accepted samples.
  - DONE → CHECK on start.
  - DONE holds otherwise.
- start (any state) clears err_count, cov_mask, the sample counter, the first-fail registers and the first-fail flag, then enters CHECK. A sample presented with start is ignored.
- Samples are accepted only in CHECK with in_valid=1. Samples in IDLE and DONE are ignored.
- On acceptance:
  - Set cov_mask[stim].
  - Increment the sample counter.
  - If resp ≠ golden(stim), increment err_count, holding at 2^ERR_W−1.
- Coverage and budget both met on the same sample: one transition to DONE. pass is evaluated from the final values.
- Repeated stim values add no coverage but do count against the budget.
- rst in any state: returns to IDLE and clears all outputs to 0 on the next edge, including mid-run.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, pass=0, err_count=0, cov_mask=0, first_fail_stim=0, first_fail_resp=0.
- A sample accepted at edge N is reflected in err_count, cov_mask and the first-fail registers after edge N.
- If that sample ends the run, done=1 and busy=0 after edge N. pass is valid in the same cycle.
- busy rises the cycle after the start edge.
- Back-to-back valid samples are accepted every cycle, with no backpressure.

## Configuration
- CHECKER_FIRST_FAIL_EN defined:
  - The first-fail registers are built.
  - They capture stim/resp on the first mismatch after start.
  - They hold until the next start or rst.
- Not defined:
  - No first-fail registers.
  - first_fail_stim and first_fail_resp are tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Full sweep, correct data: start, then stim 0..15 with golden resp (stim=0→3'b111, 4'hC→3'b011, 4'hF→3'b000). Required: done=1 the cycle after the 16th sample; err_count=0; cov_mask=16'hFFFF; pass=1.
- Single fault: full sweep with stim=4'hF, resp=3'b111. Required: err_count=1; pass=0. With the macro: first_fail_stim=4'hF, first_fail_resp=3'b111.
- Budget timeout: MAX_SAMPLES=32, stim=0 with correct resp on every cycle. Required: done after the 32nd sample; cov_mask=16'h0001; err_count=0; pass=0.
- Saturation: ERR_W=2, five wrong samples. Required: err_count reads 1, 2, 3, 3, 3.
- Reset mid-run: rst after 5 samples. Required: the next cycle shows every output 0 and the FSM in IDLE. in_valid samples are then ignored until start.
- Restart and simultaneity: start while busy after 3 errors, with in_valid=1 in the same cycle. Required: err_count=0 and cov_mask=0 the next cycle; busy=1; that sample is not counted.
